// File: rtl/dpwm_capture.sv
// dpwm_capture: measures period, on-times and deadtimes of a DPWM gate pair
// and flags shoot-through, out-of-order edges and loss of switching.
module dpwm_capture #(
  parameter int CW = 16
) (
  input  logic          hf_clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          c1,
  input  logic          c2,
  output logic [CW-1:0] period,
  output logic [CW-1:0] c1_on,
  output logic [CW-1:0] dt1,
  output logic [CW-1:0] c2_on,
  output logic [CW-1:0] dt2,
  output logic          meas_valid,
  output logic          overlap,
  output logic          seq_err,
  output logic          timeout
);
  typedef enum logic [2:0] {IDLE, C1_ON, DT1, C2_ON, DT2} state_t;
  localparam logic [CW-1:0] MAX = '1;
  localparam logic [CW-1:0] ONE = CW'(1);
  state_t state_q, state_d;
  // [1:0] metastable stage, [3:2] synced s1/s2, [5:4] one-cycle delayed copies
  logic [5:0] sync_q, sync_d;
  logic [CW-1:0] seg_q, seg_d, per_q, per_d;
  logic [CW-1:0] c1s_q, c1s_d, dt1s_q, dt1s_d, c2s_q, c2s_d;
  logic [CW-1:0] period_q, period_d, c1_on_q, c1_on_d, dt1_q, dt1_d;
  logic [CW-1:0] c2_on_q, c2_on_d, dt2_q, dt2_d;
  logic mv_q, mv_d, ov_q, ov_d, se_q, se_d, to_q, to_d;
  logic s1, s2, r1, f1, r2, f2, done;
  always_comb begin
    sync_d = {sync_q[3:0], c2, c1};
    s1 = sync_q[2];
    s2 = sync_q[3];
    r1 = s1 & ~sync_q[4];
    f1 = ~s1 & sync_q[4];
    r2 = s2 & ~sync_q[5];
    f2 = ~s2 & sync_q[5];
    state_d = state_q;
    seg_d = (seg_q == MAX) ? seg_q : seg_q + ONE;
    per_d = (per_q == MAX) ? per_q : per_q + ONE;
    c1s_d = c1s_q;
    dt1s_d = dt1s_q;
    c2s_d = c2s_q;
    period_d = period_q;
    c1_on_d = c1_on_q;
    dt1_d = dt1_q;
    c2_on_d = c2_on_q;
    dt2_d = dt2_q;
    mv_d = 1'b0;
    ov_d = ov_q;
    se_d = se_q;
    to_d = to_q;
    done = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      ov_d = 1'b0;
      se_d = 1'b0;
      to_d = 1'b0;
    end else begin
      if (s1 && s2) begin
        ov_d = 1'b1;
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (r1) begin
              state_d = C1_ON;
              seg_d = ONE;
              per_d = ONE;
            end else if (r2) se_d = 1'b1;
          end
          C1_ON: begin
            if (f1) begin
              c1s_d = seg_q;
              dt1s_d = r2 ? '0 : dt1s_q;
              seg_d = ONE;
              state_d = r2 ? C2_ON : DT1;
            end
          end
          DT1: begin
            // a c1 rise here means the c2 pulse went missing: restart the period
            if (r1) begin
              se_d = 1'b1;
              state_d = C1_ON;
              seg_d = ONE;
              per_d = ONE;
            end else if (r2) begin
              dt1s_d = seg_q;
              seg_d = ONE;
              state_d = C2_ON;
            end
          end
          C2_ON: begin
            if (f2) begin
              c2s_d = seg_q;
              seg_d = ONE;
              state_d = r1 ? C1_ON : DT2;
              done = r1;
            end
          end
          DT2: begin
            if (r1) begin
              seg_d = ONE;
              state_d = C1_ON;
              done = 1'b1;
            end else if (r2) begin
              se_d = 1'b1;
              state_d = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
      if (done) begin
        per_d = ONE;
        period_d = per_q;
        c1_on_d = c1s_q;
        dt1_d = dt1s_q;
        c2_on_d = (state_q == C2_ON) ? seg_q : c2s_q;
        dt2_d = (state_q == C2_ON) ? '0 : seg_q;
        mv_d = 1'b1;
      end
      if (state_d != IDLE && (seg_d == MAX || per_d == MAX)) begin
        to_d = 1'b1;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge hf_clock) sync_q <= sync_d;
  always_ff @(posedge hf_clock) begin
    if (!reset) begin
      state_q <= IDLE;
      seg_q <= '0;
      per_q <= '0;
      c1s_q <= '0;
      dt1s_q <= '0;
      c2s_q <= '0;
      period_q <= '0;
      c1_on_q <= '0;
      dt1_q <= '0;
      c2_on_q <= '0;
      dt2_q <= '0;
      mv_q <= 1'b0;
      ov_q <= 1'b0;
      se_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q <= seg_d;
      per_q <= per_d;
      c1s_q <= c1s_d;
      dt1s_q <= dt1s_d;
      c2s_q <= c2s_d;
      period_q <= period_d;
      c1_on_q <= c1_on_d;
      dt1_q <= dt1_d;
      c2_on_q <= c2_on_d;
      dt2_q <= dt2_d;
      mv_q <= mv_d;
      ov_q <= ov_d;
      se_q <= se_d;
      to_q <= to_d;
    end
  end
  assign period = period_q;
  assign c1_on = c1_on_q;
  assign dt1 = dt1_q;
  assign c2_on = c2_on_q;
  assign dt2 = dt2_q;
  assign meas_valid = mv_q;
  assign overlap = ov_q;
  assign seq_err = se_q;
  assign timeout = to_q;
endmodule

// File: tb/tb_dpwm_capture.sv
// tb_dpwm_capture: directed scenarios plus randomized gate waveforms against a
// timestamp-based reference model; a scoreboard monitor checks every cycle.
module tb_dpwm_capture;
  localparam int CW = 8;
  localparam int MAXV = (1 << CW) - 1;
  localparam int SW = 4 + 5 * CW;
  logic hf_clock = 1'b0, reset = 1'b0, enable = 1'b1, c1 = 1'b0, c2 = 1'b0;
  logic [CW-1:0] period, c1_on, dt1, c2_on, dt2;
  logic meas_valid, overlap, seq_err, timeout;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct packed { int cyc; logic [5*CW-1:0] v; } meas_t;
  meas_t mq[$];
  logic [SW-1:0] sq[$];

  dpwm_capture #(.CW(CW)) dut (
    .hf_clock(hf_clock), .reset(reset), .enable(enable), .c1(c1), .c2(c2),
    .period(period), .c1_on(c1_on), .dt1(dt1), .c2_on(c2_on), .dt2(dt2),
    .meas_valid(meas_valid), .overlap(overlap), .seq_err(seq_err), .timeout(timeout)
  );

  always #5 hf_clock = ~hf_clock;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input int n, input logic v1, input logic v2);
    c1 = v1;
    c2 = v2;
    repeat (n) @(negedge hf_clock);
  endtask

  task automatic pwm(input int h1, input int d1, input int h2, input int d2);
    drive(h1, 1'b1, 1'b0);
    drive(d1, 1'b0, 1'b0);
    drive(h2, 1'b0, 1'b1);
    drive(d2, 1'b0, 1'b0);
  endtask

  // Reference model: segment lengths are differences of edge timestamps.
  // Inputs sampled at edge j reach the measuring logic two edges later.
  initial begin : model
    logic [3:0] q1, q2;
    logic s1, s2, r1, f1, r2, f2, mv, ov, se, to, done;
    int ph, t_start, t_seg;
    int d[4];
    int o[5];
    q1 = '0; q2 = '0; ph = 0; t_start = 0; t_seg = 0;
    ov = 0; se = 0; to = 0;
    d = '{default: 0};
    o = '{default: 0};
    forever begin
      @(posedge hf_clock);
      cyc++;
      q1 = {q1[2:0], c1};
      q2 = {q2[2:0], c2};
      s1 = q1[2]; s2 = q2[2];
      r1 = s1 && !q1[3]; f1 = !s1 && q1[3];
      r2 = s2 && !q2[3]; f2 = !s2 && q2[3];
      mv = 0;
      done = 0;
      if (!reset) begin
        ph = 0; ov = 0; se = 0; to = 0;
        o = '{default: 0};
      end else if (!enable) begin
        ph = 0; ov = 0; se = 0; to = 0;
      end else begin
        if (s1 && s2) begin
          ov = 1; ph = 0;
        end else if (ph == 0) begin
          if (r1) begin ph = 1; t_start = cyc; t_seg = cyc; end
          else if (r2) se = 1;
        end else if (ph == 1) begin
          if (f1) begin
            d[0] = cyc - t_seg; t_seg = cyc;
            if (r2) begin d[1] = 0; ph = 3; end else ph = 2;
          end
        end else if (ph == 2) begin
          if (r1) begin se = 1; ph = 1; t_start = cyc; t_seg = cyc; end
          else if (r2) begin d[1] = cyc - t_seg; t_seg = cyc; ph = 3; end
        end else if (ph == 3) begin
          if (f2) begin
            d[2] = cyc - t_seg; t_seg = cyc;
            if (r1) begin d[3] = 0; done = 1; end else ph = 4;
          end
        end else begin
          if (r1) begin d[3] = cyc - t_seg; done = 1; end
          else if (r2) begin se = 1; ph = 0; end
        end
        if (done) begin
          o[0] = cyc - t_start;
          for (int i = 0; i < 4; i++) o[i+1] = d[i];
          mv = 1; ph = 1; t_start = cyc; t_seg = cyc;
          mq.push_back('{cyc, {CW'(o[0]), CW'(o[1]), CW'(o[2]), CW'(o[3]), CW'(o[4])}});
        end
        if (ph != 0 && (cyc + 1 - t_seg >= MAXV || cyc + 1 - t_start >= MAXV)) begin
          to = 1; ph = 0;
        end
      end
      sq.push_back({mv, ov, se, to, CW'(o[0]), CW'(o[1]), CW'(o[2]), CW'(o[3]), CW'(o[4])});
    end
  end

  initial begin : monitor
    logic [SW-1:0] act, e;
    meas_t m;
    forever begin
      @(negedge hf_clock);
      if (sq.size() != 0) begin
        act = {meas_valid, overlap, seq_err, timeout, period, c1_on, dt1, c2_on, dt2};
        e = sq.pop_front();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL status cyc=%0d got=%h expected=%h", cyc, act, e);
        end
        if (meas_valid) begin
          checks++;
          if (mq.size() == 0) begin
            errors++;
            $display("FAIL meas cyc=%0d got unexpected meas_valid expected none", cyc);
          end else begin
            m = mq.pop_front();
            if (m.cyc != cyc || m.v !== act[5*CW-1:0]) begin
              errors++;
              $display("FAIL meas cyc=%0d got=%h expected=%h at cyc %0d", cyc, act[5*CW-1:0], m.v, m.cyc);
            end
          end
        end else if (mq.size() != 0 && mq[0].cyc <= cyc) begin
          checks++;
          errors++;
          m = mq.pop_front();
          $display("FAIL meas cyc=%0d got no meas_valid expected=%h", cyc, m.v);
        end
      end
    end
  end

  initial begin : stim
    int k;
    repeat (5) @(negedge hf_clock);
    chk("reset_period", period, 0);
    chk("reset_valid", meas_valid, 0);
    reset = 1'b1;
    drive(10, 0, 0);
    // nominal
    repeat (3) pwm(40, 10, 40, 10);
    drive(5, 1, 0);
    chk("nom_period", period, 100);
    chk("nom_c1_on", c1_on, 40);
    chk("nom_dt1", dt1, 10);
    chk("nom_c2_on", c2_on, 40);
    chk("nom_dt2", dt2, 10);
    chk("nom_flags", {overlap, seq_err, timeout}, 0);
    pwm(35, 10, 40, 10);
    // zero deadtime
    repeat (3) pwm(50, 0, 50, 0);
    drive(5, 1, 0);
    chk("zdt_period", period, 100);
    chk("zdt_c1_on", c1_on, 50);
    chk("zdt_dt1", dt1, 0);
    chk("zdt_dt2", dt2, 0);
    pwm(45, 10, 40, 10);
    // shoot-through
    drive(35, 1, 0);
    drive(3, 1, 1);
    chk("overlap_set", overlap, 1);
    drive(2, 1, 1);
    drive(35, 0, 1);
    drive(10, 0, 0);
    enable = 1'b0;
    @(negedge hf_clock);
    enable = 1'b1;
    drive(2, 0, 0);
    chk("overlap_clr", overlap, 0);
    repeat (2) pwm(40, 10, 40, 10);
    drive(5, 1, 0);
    chk("post_ovl_period", period, 100);
    pwm(35, 10, 40, 10);
    // missing c2 pulse
    drive(30, 1, 0);
    drive(20, 0, 0);
    drive(30, 1, 0);
    chk("seq_err_set", seq_err, 1);
    drive(20, 0, 0);
    drive(40, 0, 1);
    drive(10, 0, 0);
    drive(5, 1, 0);
    chk("resume_period", period, 100);
    chk("resume_c1_on", c1_on, 30);
    chk("resume_dt1", dt1, 20);
    pwm(25, 10, 40, 10);
    // reset mid C2_ON
    drive(40, 1, 0);
    drive(10, 0, 0);
    drive(20, 0, 1);
    reset = 1'b0;
    @(negedge hf_clock);
    reset = 1'b1;
    chk("rst_period", period, 0);
    chk("rst_c2_on", c2_on, 0);
    chk("rst_seq_err", seq_err, 0);
    drive(19, 0, 1);
    drive(10, 0, 0);
    pwm(40, 10, 40, 10);
    drive(5, 1, 0);
    chk("post_rst_period", period, 100);
    pwm(35, 10, 40, 10);
    // loss of switching
    drive(300, 1, 0);
    chk("timeout_set", timeout, 1);
    chk("timeout_hold", period, 100);
    drive(10, 0, 0);
    enable = 1'b0;
    @(negedge hf_clock);
    enable = 1'b1;
    // randomized waveforms with occasional faults
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 19);
      if (k == 0) begin
        drive($urandom_range(5, 40), 1, 0);
        drive($urandom_range(1, 6), 1, 1);
        drive($urandom_range(5, 40), 0, 1);
        drive($urandom_range(1, 20), 0, 0);
      end else if (k == 1) begin
        drive($urandom_range(1, 40), 1, 0);
        drive($urandom_range(1, 30), 0, 0);
      end else if (k == 2) begin
        enable = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge hf_clock);
        enable = 1'b1;
      end else if (k == 3) begin
        reset = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge hf_clock);
        reset = 1'b1;
      end else if (k == 4) begin
        pwm(130, 5, 130, 5);
      end else begin
        pwm($urandom_range(1, 60), $urandom_range(0, 30), $urandom_range(1, 60), $urandom_range(0, 30));
      end
    end
    drive(20, 0, 0);
    chk("meas_drained", mq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dpwm_capture.md
Name: dpwm_capture

Overview:
- Measures the gate pair (c1, c2) produced by the DPWM block and reports per-switching-period timing: period, c1 on-time, deadtime1, c2 on-time, deadtime2.
- Used as an on-chip monitor and loopback checker, and as a bench reference for DPWM verification.
- Also flags shoot-through (c1 and c2 high together), sequence errors and loss of switching.

Parameters:
- CW, 16, width of every measurement counter and output in hf_clock cycles.

Ports:
- hf_clock  input  1  sole clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- enable  input  1  1 = measure; 0 = hold in IDLE and clear sticky flags.
- c1  input  1  high-side gate under test; may be asynchronous to hf_clock.
- c2  input  1  low-side gate under test; may be asynchronous to hf_clock.
- period  output  CW  cycles from one c1 rise to the next.
- c1_on  output  CW  cycles c1 was high.
- dt1  output  CW  cycles from c1 fall to c2 rise.
- c2_on  output  CW  cycles c2 was high.
- dt2  output  CW  cycles from c2 fall to next c1 rise.
- meas_valid  output  1  one-cycle pulse when all five measurement outputs update together.
- overlap  output  1  sticky shoot-through flag.
- seq_err  output  1  sticky out-of-order edge flag.
- timeout  output  1  sticky counter-saturation flag.

Behaviour:
- Synchronisation and edge detection:
  - c1 and c2 each pass through a 2-flop synchronizer, giving s1 and s2.
  - Edges are detected against a 1-cycle delayed copy of s1 and s2.
  - All timing below refers to the cycle in which s1 or s2 changes.
- Reset (reset=0 at a clock edge):
  - All outputs go to 0, the FSM goes to IDLE, and all counters clear.
  - A reset asserted mid-period discards the partial measurement.
- FSM states: IDLE, C1_ON, DT1, C2_ON, DT2.
  - IDLE → C1_ON on s1 rise with s2=0.
  - C1_ON → DT1 on s1 fall with s2=0.
  - C1_ON → C2_ON on s1 fall and s2 rise in the same cycle; dt1=0.
  - DT1 → C2_ON on s2 rise.
  - C2_ON → DT2 on s2 fall.
  - C2_ON → C1_ON on s2 fall and s1 rise in the same cycle; dt2=0, and the period completes.
  - DT2 → C1_ON on s1 rise; the period completes.
- Counting:
  - The segment counter loads 1 on the state-entry cycle and increments each cycle.
  - Its value is latched into the segment register (c1_on, dt1, c2_on or dt2) on the exit transition.
  - A high time of H cycles reads as exactly H.
  - The period counter runs in parallel, loads 1 on each c1 rise and is latched at the next c1 rise.
  - period always equals c1_on+dt1+c2_on+dt2 for a valid measurement.
- Output update:
  - When a period completes in cycle N, all five outputs update and meas_valid=1 in cycle N+1.
  - Outputs then hold until the next valid period.
  - The first c1 rise after IDLE only starts a period; it produces no meas_valid.
- Faults:
  - s1=1 and s2=1 in any state: set overlap, go to IDLE, no meas_valid.
  - s1 rises in DT1 (c2 pulse missing): set seq_err, restart in C1_ON treating that edge as a new period start, discard the partial data.
  - s2 rises in DT2 or in IDLE: set seq_err, stay in or return to IDLE.
  - Segment or period counter reaches 2^CW-1: set timeout, go to IDLE; counters saturate and never wrap.
  - Flags are sticky until enable=0 or reset=0.
- enable=0:
  - FSM forced to IDLE; overlap, seq_err and timeout cleared; meas_valid held 0.
  - Measurement outputs keep their last values.
  - Re-enabling waits for a fresh c1 rise.
- All-zero inputs: the FSM waits in IDLE with no timeout; timeout is armed only outside IDLE.

Test Plan:
- Nominal, CW=16: c1 high 40, low 10, c2 high 40, low 10, repeated 3 periods → meas_valid from the 2nd c1 rise with period=100, c1_on=40, dt1=10, c2_on=40, dt2=10; overlap, seq_err and timeout all 0.
- Zero deadtime: c1 high 50, c2 high 50, complementary and switching in the same cycle → dt1=0, dt2=0, period=100, meas_valid each period.
- Shoot-through: c2 rises 5 cycles before c1 falls → overlap=1 within 3 cycles of the c2 edge, no meas_valid; enable pulsed 0 for 1 cycle clears overlap; the next clean period measures correctly.
- Missing c2 pulse: c1 high 30, low 20, high 30, and c2 held 0 → seq_err=1, no meas_valid; once c2 returns, valid measurements resume.
- Loss of switching: CW=8, c1 held high 300 cycles → timeout=1 at cycle 255 of the high time, FSM in IDLE, outputs hold their prior values.
- Reset mid-period: reset=0 for 1 cycle during C2_ON → all outputs 0 the next cycle; the first meas_valid appears only after two further c1 rises.
